// File: rtl/usb_bus_master.sv
// Register-interface bus master: turns one accepted command into an
// ALEn/CEn/RDn/WRn strobe sequence with fully registered bus outputs.
module usb_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 32'd1,
    parameter int unsigned STROBE_CYCLES = 32'd2,
    parameter int unsigned HOLD_CYCLES   = 32'd1
) (
    input  logic       clk_usb,
    input  logic       reset_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [7:0] USB_Addr,
    output logic [7:0] USB_D_o,
    output logic       USB_D_oe,
    input  logic [7:0] USB_D_i,
    output logic       USB_ALEn,
    output logic       USB_CEn,
    output logic       USB_RDn,
    output logic       USB_WRn
);

    // Phase length clamped to 1..255 and converted to a down-counter preload.
    function automatic logic [7:0] load_value(input int unsigned cycles);
        if (cycles == 32'd0) begin
            return 8'd0;
        end else if (cycles > 32'd255) begin
            return 8'd254;
        end else begin
            return 8'(cycles - 32'd1);
        end
    endfunction

    localparam logic [7:0] SETUP_LOAD  = load_value(SETUP_CYCLES);
    localparam logic [7:0] STROBE_LOAD = load_value(STROBE_CYCLES);
    localparam logic [7:0] HOLD_LOAD   = load_value(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       write_r;
    logic [7:0] wdata_r;

    // Transaction sequencer; every bus and handshake output is a register here.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            write_r   <= 1'b0;
            wdata_r   <= 8'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            busy      <= 1'b0;
            USB_Addr  <= 8'd0;
            USB_D_o   <= 8'd0;
            USB_D_oe  <= 1'b0;
            USB_ALEn  <= 1'b1;
            USB_CEn   <= 1'b1;
            USB_RDn   <= 1'b1;
            USB_WRn   <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state_r   <= ADDR;
                        cnt_r     <= SETUP_LOAD;
                        write_r   <= cmd_write;
                        wdata_r   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        USB_Addr  <= cmd_addr;
                        USB_ALEn  <= 1'b0;
                        USB_CEn   <= 1'b0;
                    end
                end
                ADDR: begin
                    if (cnt_r == 8'd0) begin
                        state_r  <= STROBE;
                        cnt_r    <= STROBE_LOAD;
                        USB_ALEn <= 1'b1;
                        if (write_r) begin
                            USB_WRn  <= 1'b0;
                            USB_D_oe <= 1'b1;
                            USB_D_o  <= wdata_r;
                        end else begin
                            USB_RDn  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= HOLD;
                        cnt_r   <= HOLD_LOAD;
                        USB_RDn <= 1'b1;
                        USB_WRn <= 1'b1;
                        // Capture on the edge that ends the last strobe cycle, RDn still low.
                        if (!write_r) begin
                            rsp_rdata <= USB_D_i;
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_r == 8'd0) begin
                        state_r   <= IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                        USB_CEn   <= 1'b1;
                        USB_D_oe  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 8'd0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                    USB_D_oe  <= 1'b0;
                    USB_ALEn  <= 1'b1;
                    USB_CEn   <= 1'b1;
                    USB_RDn   <= 1'b1;
                    USB_WRn   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bus_master.sv
// Bench for usb_bus_master: three parameterisations share one stimulus stream
// and are compared every cycle against a timeline model of the transaction.
module tb_usb_bus_master;

    logic       clk_usb = 1'b0;
    logic       rst, vld, wr;
    logic [7:0] addr_i, wdata_i, din;

    logic [2:0] rdy, rv, busy_o, oe, alen, cen, rdn, wrn;
    logic [7:0] rdata_o [3];
    logic [7:0] addr_o  [3];
    logic [7:0] do_o    [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_usb = ~clk_usb;

    usb_bus_master dut0 (
        .clk_usb(clk_usb), .reset_i(rst), .cmd_valid(vld), .cmd_ready(rdy[0]),
        .cmd_write(wr), .cmd_addr(addr_i), .cmd_wdata(wdata_i),
        .rsp_valid(rv[0]), .rsp_rdata(rdata_o[0]), .busy(busy_o[0]),
        .USB_Addr(addr_o[0]), .USB_D_o(do_o[0]), .USB_D_oe(oe[0]), .USB_D_i(din),
        .USB_ALEn(alen[0]), .USB_CEn(cen[0]), .USB_RDn(rdn[0]), .USB_WRn(wrn[0]));

    usb_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(5), .HOLD_CYCLES(2)) dut1 (
        .clk_usb(clk_usb), .reset_i(rst), .cmd_valid(vld), .cmd_ready(rdy[1]),
        .cmd_write(wr), .cmd_addr(addr_i), .cmd_wdata(wdata_i),
        .rsp_valid(rv[1]), .rsp_rdata(rdata_o[1]), .busy(busy_o[1]),
        .USB_Addr(addr_o[1]), .USB_D_o(do_o[1]), .USB_D_oe(oe[1]), .USB_D_i(din),
        .USB_ALEn(alen[1]), .USB_CEn(cen[1]), .USB_RDn(rdn[1]), .USB_WRn(wrn[1]));

    usb_bus_master #(.SETUP_CYCLES(0)) dut2 (
        .clk_usb(clk_usb), .reset_i(rst), .cmd_valid(vld), .cmd_ready(rdy[2]),
        .cmd_write(wr), .cmd_addr(addr_i), .cmd_wdata(wdata_i),
        .rsp_valid(rv[2]), .rsp_rdata(rdata_o[2]), .busy(busy_o[2]),
        .USB_Addr(addr_o[2]), .USB_D_o(do_o[2]), .USB_D_oe(oe[2]), .USB_D_i(din),
        .USB_ALEn(alen[2]), .USB_CEn(cen[2]), .USB_RDn(rdn[2]), .USB_WRn(wrn[2]));

    // Effective phase lengths of each instance (SETUP=0 behaves as 1).
    int s_eff [3] = '{1, 3, 1};
    int t_eff [3] = '{2, 5, 2};
    int h_eff [3] = '{1, 2, 1};

    // Model: a transaction is just "t cycles since acceptance".
    bit         m_act [3];
    int         m_t   [3];
    bit         m_w   [3];
    bit         m_rdy [3];
    bit         m_rv  [3];
    logic [7:0] m_addr  [3];
    logic [7:0] m_wd    [3];
    logic [7:0] m_rdata [3];

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, got, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_act[i] = 1'b0; m_t[i] = 0; m_rdy[i] = 1'b0; m_rv[i] = 1'b0;
                m_addr[i] = 8'h00; m_rdata[i] = 8'h00;
            end else begin
                m_rv[i] = 1'b0;
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == s_eff[i] + t_eff[i] + 1 && !m_w[i]) m_rdata[i] = din;
                    if (m_t[i] == s_eff[i] + t_eff[i] + h_eff[i] + 1) begin
                        m_act[i] = 1'b0; m_rv[i] = 1'b1; m_rdy[i] = 1'b1;
                    end
                end else if (vld && m_rdy[i]) begin
                    m_act[i] = 1'b1; m_t[i] = 1; m_rdy[i] = 1'b0;
                    m_w[i] = wr; m_addr[i] = addr_i; m_wd[i] = wdata_i;
                end else begin
                    m_rdy[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            bit in_addr, in_strb, e_oe;
            in_addr = m_act[i] && m_t[i] <= s_eff[i];
            in_strb = m_act[i] && m_t[i] > s_eff[i] && m_t[i] <= s_eff[i] + t_eff[i];
            e_oe    = m_act[i] && m_w[i] && m_t[i] > s_eff[i];
            chk("ALEn", i, alen[i], !in_addr);
            chk("CEn", i, cen[i], !m_act[i]);
            chk("RDn", i, rdn[i], !(in_strb && !m_w[i]));
            chk("WRn", i, wrn[i], !(in_strb && m_w[i]));
            chk("D_oe", i, oe[i], e_oe);
            chk("busy", i, busy_o[i], m_act[i]);
            chk("cmd_ready", i, rdy[i], m_rdy[i]);
            chk("rsp_valid", i, rv[i], m_rv[i]);
            chk("Addr", i, addr_o[i], m_addr[i]);
            chk("rsp_rdata", i, rdata_o[i], m_rdata[i]);
            if (e_oe) chk("D_o", i, do_o[i], m_wd[i]);
            chk("strobe_excl", i, rdn[i] | wrn[i], 1'b1);
            chk("ale_vs_strobe", i, alen[i] | (rdn[i] & wrn[i]), 1'b1);
        end
    endtask

    task automatic tick();
        @(posedge clk_usb);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic r, input logic v, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] di);
        rst = r; vld = v; wr = w; addr_i = a; wdata_i = d; din = di;
    endtask

    typedef struct {
        logic       rst, vld, wr;
        logic [7:0] addr, wdata, din;
        logic       alen, cen, rdn, wrn, oe, rv, rdy, busy;
        logic [7:0] e_addr, e_rdata, e_do;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] alen_mask, cen_mask, rv_mask;
        int rv_cyc [3];
        int alen_cnt [3];
        int rdn_cnt [3];

        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77);

        // Default-parameter write (0x04/0xA5) then read (0x1F, 0x3C on the bus).
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'h77, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00};
        tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'h77, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 8'h00,8'h00,8'h00};
        tbl[2]  = '{1'b0,1'b1,1'b1,8'h04,8'hA5,8'h77, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 8'h04,8'h00,8'h00};
        tbl[3]  = '{1'b0,1'b0,1'b0,8'hEE,8'h11,8'h77, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 8'h04,8'h00,8'hA5};
        tbl[4]  = '{1'b0,1'b0,1'b0,8'hEE,8'h11,8'h77, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 8'h04,8'h00,8'hA5};
        tbl[5]  = '{1'b0,1'b0,1'b0,8'hEE,8'h11,8'h77, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 8'h04,8'h00,8'hA5};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'hEE,8'h11,8'h77, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 8'h04,8'h00,8'h00};
        tbl[7]  = '{1'b0,1'b1,1'b0,8'h1F,8'h22,8'h77, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 8'h1F,8'h00,8'h00};
        tbl[8]  = '{1'b0,1'b0,1'b1,8'h55,8'h66,8'h77, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 8'h1F,8'h00,8'h00};
        tbl[9]  = '{1'b0,1'b0,1'b1,8'h55,8'h66,8'h3C, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 8'h1F,8'h00,8'h00};
        tbl[10] = '{1'b0,1'b0,1'b1,8'h55,8'h66,8'h3C, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 8'h1F,8'h3C,8'h00};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'h77, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 8'h1F,8'h3C,8'h00};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'h77, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 8'h1F,8'h3C,8'h00};

        for (int r = 0; r < 13; r++) begin
            set_in(tbl[r].rst, tbl[r].vld, tbl[r].wr, tbl[r].addr, tbl[r].wdata, tbl[r].din);
            tick();
            chk("tbl_ALEn", r, alen[0], tbl[r].alen);
            chk("tbl_CEn", r, cen[0], tbl[r].cen);
            chk("tbl_RDn", r, rdn[0], tbl[r].rdn);
            chk("tbl_WRn", r, wrn[0], tbl[r].wrn);
            chk("tbl_D_oe", r, oe[0], tbl[r].oe);
            chk("tbl_rsp_valid", r, rv[0], tbl[r].rv);
            chk("tbl_cmd_ready", r, rdy[0], tbl[r].rdy);
            chk("tbl_busy", r, busy_o[0], tbl[r].busy);
            chk("tbl_Addr", r, addr_o[0], tbl[r].e_addr);
            chk("tbl_rsp_rdata", r, rdata_o[0], tbl[r].e_rdata);
            if (tbl[r].oe) chk("tbl_D_o", r, do_o[0], tbl[r].e_do);
            if (r == 0) chk("tbl_D_o_reset", r, do_o[0], 8'h00);
        end

        // Reset in the first strobe cycle of a write aborts it without a response.
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b1, 1'b1, 8'h40, 8'h99, 8'h00); tick();
        vld = 1'b0; tick();
        chk("rst_mid_wrn_low", 0, wrn[0], 1'b0);
        rst = 1'b1; tick();
        chk("rst_mid_wrn", 0, wrn[0], 1'b1);
        chk("rst_mid_cen", 0, cen[0], 1'b1);
        chk("rst_mid_oe", 0, oe[0], 1'b0);
        chk("rst_mid_rv", 0, rv[0], 1'b0);
        rst = 1'b0; tick();
        chk("rst_rel_ready", 0, rdy[0], 1'b1);
        chk("rst_rel_rv", 0, rv[0], 1'b0);
        tick();
        chk("rst_after_rv", 0, rv[0], 1'b0);

        // Back-to-back with cmd_valid held: write then read.
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 8'h00);
        alen_mask = 32'd0; cen_mask = 32'd0; rv_mask = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (!alen[0]) alen_mask[c] = 1'b1;
            if (cen[0] && c <= 9) cen_mask[c] = 1'b1;
            if (rv[0]) rv_mask[c] = 1'b1;
            if (c == 1) set_in(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 8'hC3);
            if (c == 6) vld = 1'b0;
        end
        chk("b2b_ale_cycles", 0, alen_mask, 32'h0000_0042);
        chk("b2b_cen_gap", 0, cen_mask, 32'h0000_0020);
        chk("b2b_rsp_cycles", 0, rv_mask, 32'h0000_0420);

        // Latency and phase lengths per parameterisation for one read.
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        set_in(1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h9E);
        for (int i = 0; i < 3; i++) begin rv_cyc[i] = 0; alen_cnt[i] = 0; rdn_cnt[i] = 0; end
        for (int c = 1; c <= 20; c++) begin
            tick();
            vld = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!alen[i]) alen_cnt[i]++;
                if (!rdn[i]) rdn_cnt[i]++;
                if (rv[i] && rv_cyc[i] == 0) rv_cyc[i] = c;
            end
        end
        chk("lat_rsp", 0, rv_cyc[0], 5);
        chk("lat_rsp", 1, rv_cyc[1], 11);
        chk("lat_rsp", 2, rv_cyc[2], 5);
        chk("ale_len", 0, alen_cnt[0], 1);
        chk("ale_len", 1, alen_cnt[1], 3);
        chk("ale_len", 2, alen_cnt[2], 1);
        chk("rdn_len", 0, rdn_cnt[0], 2);
        chk("rdn_len", 1, rdn_cnt[1], 5);
        chk("rdn_len", 2, rdn_cnt[2], 2);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
